// File: rtl/afe_spi_sequencer_if.sv
// Request/status/SPI-pin bundle of the AFE SPI sequencer.
// The master drives requests; the slave (sequencer) drives status and pins.
interface afe_spi_sequencer_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  csrStrobe;
    logic [31:0]           csrData;
    logic                  csrOverrunClear;
    logic [31:0]           csrStatus;
    logic                  autoReq;
    logic                  autoTarget;
    logic [WORD_WIDTH-1:0] autoData;
    logic                  autoAck;
    logic [1:0]            spiClk;
    logic [1:0]            spiSdi;
    logic [1:0]            spiLe;

    modport master (
        output csrStrobe, csrData, csrOverrunClear,
        output autoReq, autoTarget, autoData,
        input  csrStatus, autoAck,
        input  spiClk, spiSdi, spiLe
    );

    modport slave (
        input  csrStrobe, csrData, csrOverrunClear,
        input  autoReq, autoTarget, autoData,
        output csrStatus, autoAck,
        output spiClk, spiSdi, spiLe
    );
endinterface

// File: rtl/afe_spi_sequencer.sv
// Shared SPI shift engine for the two AFE boards, arbitrated
// round-robin between a CSR pending slot and an auto requester.
module afe_spi_sequencer #(
    parameter int WORD_WIDTH = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic               sysClk,
    input  logic               sysReset_n,
    afe_spi_sequencer_if.slave bus
);
    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam logic [7:0]    HALF_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0]    HALF_ONE  = 8'd1;
    localparam logic [BW-1:0] BIT_LOAD  = BW'(WORD_WIDTH);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    typedef enum logic [2:0] {
        IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            half_q, half_d;
    logic [BW-1:0]         bits_q, bits_d;
    logic [WORD_WIDTH-1:0] sh_q, sh_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  tgt_q, tgt_d;
    logic                  pend_q, pend_d;
    logic                  pend_tgt_q, pend_tgt_d;
    logic [WORD_WIDTH-1:0] pend_word_q, pend_word_d;
    logic                  ovr_q, ovr_d;
    logic                  prio_auto_q, prio_auto_d;
    logic                  ack_q, ack_d;
    logic                  last_tgt_q, last_tgt_d;
    logic [WORD_WIDTH-1:0] last_word_q, last_word_d;
    logic                  areq_q, areq_d;
    logic                  atgt_q, atgt_d;
    logic [WORD_WIDTH-1:0] adata_q, adata_d;
    logic [1:0]            clk_q, clk_d;
    logic [1:0]            sdi_q, sdi_d;
    logic [1:0]            le_q, le_d;
    logic                  grant_csr;
    logic                  grant_auto;
    logic                  unused_csr_bits;

    assign unused_csr_bits = ^bus.csrData[30:WORD_WIDTH];

    // Arbitration, sequencing, CSR slot and next-cycle pin values
    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        bits_d      = bits_q;
        sh_d        = sh_q;
        word_d      = word_q;
        tgt_d       = tgt_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        pend_word_d = pend_word_q;
        ovr_d       = ovr_q;
        prio_auto_d = prio_auto_q;
        ack_d       = 1'b0;
        last_tgt_d  = last_tgt_q;
        last_word_d = last_word_q;
        areq_d      = bus.autoReq;
        atgt_d      = bus.autoTarget;
        adata_d     = bus.autoData;
        grant_csr   = 1'b0;
        grant_auto  = 1'b0;

        if (state_q == IDLE) begin
            if (pend_q && !(areq_q && prio_auto_q)) begin
                grant_csr = 1'b1;
            end else if (areq_q) begin
                grant_auto = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (grant_csr || grant_auto) begin
                    state_d     = SHIFT_LO;
                    half_d      = HALF_LOAD;
                    bits_d      = BIT_LOAD;
                    sh_d        = grant_csr ? pend_word_q : adata_q;
                    word_d      = sh_d;
                    tgt_d       = grant_csr ? pend_tgt_q : atgt_q;
                    prio_auto_d = grant_csr;
                    ack_d       = grant_auto;
                end
            end
            SHIFT_LO: begin
                if (half_q == 8'd0) begin
                    state_d = SHIFT_HI;
                    half_d  = HALF_LOAD;
                end else begin
                    half_d = half_q - HALF_ONE;
                end
            end
            SHIFT_HI: begin
                if (half_q == 8'd0) begin
                    half_d = HALF_LOAD;
                    sh_d   = {sh_q[WORD_WIDTH-2:0], 1'b0};
                    if (bits_q == BIT_ONE) begin
                        state_d = LATCH;
                        bits_d  = '0;
                    end else begin
                        state_d = SHIFT_LO;
                        bits_d  = bits_q - BIT_ONE;
                    end
                end else begin
                    half_d = half_q - HALF_ONE;
                end
            end
            LATCH: begin
                if (half_q == 8'd0) begin
                    state_d = GAP;
                    half_d  = HALF_LOAD;
                end else begin
                    half_d = half_q - HALF_ONE;
                end
            end
            GAP: begin
                if (half_q == 8'd0) begin
                    state_d     = IDLE;
                    last_tgt_d  = tgt_q;
                    last_word_d = word_q;
                end else begin
                    half_d = half_q - HALF_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_csr) pend_d = 1'b0;
        if (bus.csrOverrunClear) ovr_d = 1'b0;
        if (bus.csrStrobe) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_tgt_d  = bus.csrData[31];
                pend_word_d = bus.csrData[WORD_WIDTH-1:0];
            end
        end

        clk_d = '0;
        sdi_d = '0;
        le_d  = '0;
        unique case (state_d)
            SHIFT_LO: sdi_d[tgt_d] = sh_d[WORD_WIDTH-1];
            SHIFT_HI: begin
                clk_d[tgt_d] = 1'b1;
                sdi_d[tgt_d] = sh_d[WORD_WIDTH-1];
            end
            LATCH:   le_d[tgt_d] = 1'b1;
            default: ;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_q     <= IDLE;
            half_q      <= '0;
            bits_q      <= '0;
            sh_q        <= '0;
            word_q      <= '0;
            tgt_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_tgt_q  <= 1'b0;
            pend_word_q <= '0;
            ovr_q       <= 1'b0;
            prio_auto_q <= 1'b0;
            ack_q       <= 1'b0;
            last_tgt_q  <= 1'b0;
            last_word_q <= '0;
            areq_q      <= 1'b0;
            atgt_q      <= 1'b0;
            adata_q     <= '0;
            clk_q       <= '0;
            sdi_q       <= '0;
            le_q        <= '0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            bits_q      <= bits_d;
            sh_q        <= sh_d;
            word_q      <= word_d;
            tgt_q       <= tgt_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_word_q <= pend_word_d;
            ovr_q       <= ovr_d;
            prio_auto_q <= prio_auto_d;
            ack_q       <= ack_d;
            last_tgt_q  <= last_tgt_d;
            last_word_q <= last_word_d;
            areq_q      <= areq_d;
            atgt_q      <= atgt_d;
            adata_q     <= adata_d;
            clk_q       <= clk_d;
            sdi_q       <= sdi_d;
            le_q        <= le_d;
        end
    end

    assign bus.csrStatus = {state_q != IDLE, pend_q, ovr_q, last_tgt_q,
                            {(28 - WORD_WIDTH){1'b0}}, last_word_q};
    assign bus.autoAck   = ack_q;
    assign bus.spiClk    = clk_q;
    assign bus.spiSdi    = sdi_q;
    assign bus.spiLe     = le_q;
endmodule

// File: tb/tb_afe_spi_sequencer.sv
// Bench for afe_spi_sequencer: pin-level frame decoder plus an
// ordering/timing reference model of the arbitration rules.
module tb_afe_spi_sequencer;
    localparam int W    = 16;
    localparam int D    = 4;
    localparam int D2   = 2;
    localparam int TLEN = (2 * W + 2) * D;
    localparam int TL2  = (2 * W + 2) * D2;

    typedef struct {
        int           board;
        logic [W-1:0] word;
        int           nb;
        int           le;
    } frame_t;

    logic sysClk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 sysClk = ~sysClk;

    afe_spi_sequencer_if #(.WORD_WIDTH(W)) bus ();
    afe_spi_sequencer_if #(.WORD_WIDTH(W)) bus2 ();

    afe_spi_sequencer #(.WORD_WIDTH(W), .CLK_DIV(D)) dut (
        .sysClk     (sysClk),
        .sysReset_n (rst_n),
        .bus        (bus)
    );

    afe_spi_sequencer #(.WORD_WIDTH(W), .CLK_DIV(D2)) dut2 (
        .sysClk     (sysClk),
        .sysReset_n (rst_n),
        .bus        (bus2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // pin monitor state (dut)
    frame_t       frames[$];
    int           busy_lens[$];
    logic [W-1:0] acc[2];
    int           mon_nb[2];
    int           lec[2];
    logic         pclk[2];
    logic         ple[2];
    logic         psdi[2];
    int           act[2];
    int           xviol = 0;
    int           sviol = 0;
    int           ack_cnt = 0;
    int           ack_long = 0;
    logic         pack = 1'b0;
    logic         pbusy = 1'b0;
    int           bcnt = 0;

    // pin monitor state (dut2)
    int   lens2[$];
    int   gaps2[$];
    int   bc2 = 0;
    int   g2 = 0;
    int   ack2 = 0;
    logic pb2 = 1'b0;
    logic seen2 = 1'b0;

    // reference model state
    frame_t exp_q[$];
    bit     m_prio_auto = 1'b0;

    initial begin
        for (int b = 0; b < 2; b++) begin
            acc[b] = '0; mon_nb[b] = 0; lec[b] = 0;
            pclk[b] = 0; ple[b] = 0; psdi[b] = 0; act[b] = 0;
        end
    end

    always @(negedge sysClk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                acc[b] = '0; mon_nb[b] = 0; lec[b] = 0;
                pclk[b] = 0; ple[b] = 0; psdi[b] = 0;
            end
            pbusy = 0; bcnt = 0; pack = 0;
        end else begin
            if ((|{bus.spiClk[0], bus.spiSdi[0], bus.spiLe[0]}) &&
                (|{bus.spiClk[1], bus.spiSdi[1], bus.spiLe[1]}))
                xviol++;
            for (int b = 0; b < 2; b++) begin
                if (bus.spiClk[b] || bus.spiSdi[b] || bus.spiLe[b])
                    act[b]++;
                if (pclk[b] && bus.spiClk[b] && bus.spiSdi[b] !== psdi[b])
                    sviol++;
                if (bus.spiClk[b] && !pclk[b]) begin
                    acc[b] = {acc[b][W-2:0], bus.spiSdi[b]};
                    mon_nb[b]++;
                end
                if (bus.spiLe[b]) lec[b]++;
                if (!bus.spiLe[b] && ple[b]) begin
                    frames.push_back('{b, acc[b], mon_nb[b], lec[b]});
                    acc[b] = '0; mon_nb[b] = 0; lec[b] = 0;
                end
                pclk[b] = bus.spiClk[b];
                ple[b]  = bus.spiLe[b];
                psdi[b] = bus.spiSdi[b];
            end
            if (bus.autoAck) ack_cnt++;
            if (bus.autoAck && pack) ack_long++;
            pack = bus.autoAck;
            if (bus.csrStatus[31]) begin
                bcnt++;
            end else if (pbusy) begin
                busy_lens.push_back(bcnt);
                bcnt = 0;
            end
            pbusy = bus.csrStatus[31];
        end
        if (rst_n) begin
            if (bus2.autoAck) ack2++;
            if (bus2.csrStatus[31]) begin
                if (!pb2 && seen2) gaps2.push_back(g2);
                bc2++;
            end else begin
                if (pb2) begin
                    lens2.push_back(bc2);
                    bc2 = 0; seen2 = 1; g2 = 0;
                end
                g2++;
            end
            pb2 = bus2.csrStatus[31];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_csr(input logic t, input logic [W-1:0] w);
        exp_q.push_back('{int'(t), w, W, D});
        m_prio_auto = 1'b1;
    endtask

    task automatic m_auto(input logic t, input logic [W-1:0] w);
        exp_q.push_back('{int'(t), w, W, D});
        m_prio_auto = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        int     n;
        frame_t e;
        frame_t f;
        frame_t last;
        n = exp_q.size();
        last = '{0, '0, 0, 0};
        for (int i = 0; i < 6000; i++) begin
            @(negedge sysClk);
            if (frames.size() >= n && busy_lens.size() >= n &&
                !bus.csrStatus[31]) break;
        end
        chk({tag, "_nframes"}, frames.size(), n);
        chk({tag, "_nbusy"}, busy_lens.size(), n);
        while (exp_q.size() > 0 && frames.size() > 0) begin
            e = exp_q.pop_front();
            f = frames.pop_front();
            chk({tag, "_board"}, f.board, e.board);
            chk({tag, "_word"}, 32'(f.word), 32'(e.word));
            chk({tag, "_nbits"}, f.nb, e.nb);
            chk({tag, "_le_len"}, f.le, e.le);
            last = e;
        end
        while (busy_lens.size() > 0)
            chk({tag, "_busy_len"}, busy_lens.pop_front(), TLEN);
        if (n > 0) begin
            chk({tag, "_st_word"}, 32'(bus.csrStatus[W-1:0]),
                32'(last.word));
            chk({tag, "_st_tgt"}, 32'(bus.csrStatus[28]), last.board);
        end
        exp_q.delete();
        frames.delete();
    endtask

    task automatic issue(input int kind, input logic ct,
                         input logic [W-1:0] cw, input logic at,
                         input logic [W-1:0] aw);
        int   a0;
        logic got;
        a0 = ack_cnt;
        got = 1'b0;
        @(posedge sysClk); #1;
        if (kind != 1) begin
            bus.csrStrobe = 1'b1;
            bus.csrData   = {ct, 15'($urandom), cw};
        end
        if (kind != 0) begin
            bus.autoReq    = 1'b1;
            bus.autoTarget = at;
            bus.autoData   = aw;
        end
        @(posedge sysClk); #1;
        bus.csrStrobe = 1'b0;
        if (kind != 0) begin
            for (int i = 0; i < 2 * TLEN + 20; i++) begin
                @(negedge sysClk);
                got = bus.autoAck;
                if (got) break;
            end
            chk("ack_seen", 32'(got), 1);
            @(posedge sysClk); #1;
            bus.autoReq = 1'b0;
        end
        if (kind == 0) m_csr(ct, cw);
        else if (kind == 1) m_auto(at, aw);
        else if (m_prio_auto) begin m_auto(at, aw); m_csr(ct, cw); end
        else begin m_csr(ct, cw); m_auto(at, aw); end
        expect_done("issue");
        chk("ack_count", ack_cnt - a0, (kind != 0) ? 1 : 0);
    endtask

    task automatic do_reset();
        @(posedge sysClk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge sysClk);
        #1 rst_n = 1'b1;
        m_prio_auto = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [W-1:0] w;
        logic         t;
        int           a0;
        bus.csrStrobe = 0; bus.csrData = '0; bus.csrOverrunClear = 0;
        bus.autoReq = 0; bus.autoTarget = 0; bus.autoData = '0;
        bus2.csrStrobe = 0; bus2.csrData = '0; bus2.csrOverrunClear = 0;
        bus2.autoReq = 0; bus2.autoTarget = 0; bus2.autoData = '0;

        // reset state
        repeat (3) @(posedge sysClk);
        #1;
        chk("rst_status", bus.csrStatus, 0);
        chk("rst_clk", 32'(bus.spiClk), 0);
        chk("rst_sdi", 32'(bus.spiSdi), 0);
        chk("rst_le", 32'(bus.spiLe), 0);
        chk("rst_ack", 32'(bus.autoAck), 0);
        rst_n = 1'b1;

        // directed CSR write to board 1
        a0 = act[0];
        @(posedge sysClk); #1;
        bus.csrStrobe = 1'b1;
        bus.csrData   = 32'h8000_A5C3;
        @(posedge sysClk); #1;
        bus.csrStrobe = 1'b0;
        chk("lat_pending", 32'(bus.csrStatus[30]), 1);
        chk("lat_busy0", 32'(bus.csrStatus[31]), 0);
        @(posedge sysClk); #1;
        chk("lat_busy1", 32'(bus.csrStatus[31]), 1);
        chk("lat_sdi_msb", 32'(bus.spiSdi), 32'h2);
        chk("lat_clk_low", 32'(bus.spiClk), 0);
        chk("lat_pend_clr", 32'(bus.csrStatus[30]), 0);
        m_csr(1'b1, 16'hA5C3);
        expect_done("csr_a5c3");
        chk("board0_quiet", act[0] - a0, 0);

        // auto request latency
        w = 16'($urandom);
        @(posedge sysClk); #1;
        bus.autoReq = 1'b1; bus.autoTarget = 1'b0; bus.autoData = w;
        @(posedge sysClk); #1;
        chk("auto_busy0", 32'(bus.csrStatus[31]), 0);
        chk("auto_ack0", 32'(bus.autoAck), 0);
        @(posedge sysClk); #1;
        chk("auto_busy1", 32'(bus.csrStatus[31]), 1);
        chk("auto_ack1", 32'(bus.autoAck), 1);
        chk("auto_sdi", 32'(bus.spiSdi), 32'({1'b0, w[W-1]}));
        @(posedge sysClk); #1;
        chk("auto_ack2", 32'(bus.autoAck), 0);
        bus.autoReq = 1'b0;
        m_auto(1'b0, w);
        expect_done("auto_lat");

        // simultaneous requests after reset, then round-robin swap
        do_reset();
        issue(2, 1'b1, 16'($urandom), 1'b0, 16'h1234);
        issue(0, 1'b0, 16'($urandom), 1'b0, 16'h0);
        issue(2, 1'b1, 16'($urandom), 1'b0, 16'h5A5A);

        // overrun while busy
        @(posedge sysClk); #1;
        bus.csrStrobe = 1'b1; bus.csrData = 32'h0000_1111;
        @(posedge sysClk); #1;
        bus.csrStrobe = 1'b0;
        repeat (4) @(posedge sysClk);
        #1;
        bus.csrStrobe = 1'b1; bus.csrData = 32'h8000_2222;
        @(posedge sysClk); #1;
        bus.csrStrobe = 1'b0;
        chk("ovr_pend1", 32'(bus.csrStatus[30]), 1);
        chk("ovr_flag0", 32'(bus.csrStatus[29]), 0);
        bus.csrStrobe = 1'b1; bus.csrData = 32'h0000_3333;
        @(posedge sysClk); #1;
        bus.csrStrobe = 1'b0;
        chk("ovr_flag1", 32'(bus.csrStatus[29]), 1);
        chk("ovr_pend2", 32'(bus.csrStatus[30]), 1);
        bus.csrOverrunClear = 1'b1;
        @(posedge sysClk); #1;
        bus.csrOverrunClear = 1'b0;
        chk("ovr_clear", 32'(bus.csrStatus[29]), 0);
        bus.csrOverrunClear = 1'b1;
        bus.csrStrobe = 1'b1; bus.csrData = 32'h0000_4444;
        @(posedge sysClk); #1;
        bus.csrOverrunClear = 1'b0;
        bus.csrStrobe = 1'b0;
        chk("ovr_set_wins", 32'(bus.csrStatus[29]), 1);
        bus.csrOverrunClear = 1'b1;
        @(posedge sysClk); #1;
        bus.csrOverrunClear = 1'b0;
        chk("ovr_clear2", 32'(bus.csrStatus[29]), 0);
        m_csr(1'b0, 16'h1111);
        m_csr(1'b1, 16'h2222);
        expect_done("ovr");

        // reset in the middle of bit 8
        t = 1'($urandom);
        @(posedge sysClk); #1;
        bus.csrStrobe = 1'b1; bus.csrData = {t, 15'h0, 16'($urandom)};
        @(posedge sysClk); #1;
        bus.csrStrobe = 1'b0;
        for (int i = 0; i < 2 * TLEN; i++) begin
            @(negedge sysClk);
            if (mon_nb[t] >= 8) break;
        end
        chk("mid_bit8", mon_nb[t], 8);
        @(posedge sysClk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_clk", 32'(bus.spiClk), 0);
        chk("mid_sdi", 32'(bus.spiSdi), 0);
        chk("mid_le", 32'(bus.spiLe), 0);
        repeat (2) @(posedge sysClk);
        #1 rst_n = 1'b1;
        #1;
        chk("mid_status", bus.csrStatus, 0);
        chk("mid_noframe", frames.size(), 0);
        chk("mid_nobusy", busy_lens.size(), 0);
        m_prio_auto = 1'b0;

        // randomized request mix
        for (int k = 0; k < 8; k++) begin
            issue(int'($urandom_range(0, 2)), 1'($urandom),
                  16'($urandom), 1'($urandom), 16'($urandom));
        end

        // back-to-back auto transfers at CLK_DIV=2
        @(posedge sysClk); #1;
        bus2.autoReq = 1'b1; bus2.autoTarget = 1'b1;
        bus2.autoData = 16'($urandom);
        for (int i = 0; i < 4 * TL2 + 40; i++) begin
            @(negedge sysClk);
            if (ack2 >= 3) break;
        end
        @(posedge sysClk); #1;
        bus2.autoReq = 1'b0;
        for (int i = 0; i < 2 * TL2 + 40; i++) begin
            @(negedge sysClk);
            if (lens2.size() >= 3 && !bus2.csrStatus[31]) break;
        end
        repeat (20) @(posedge sysClk);
        chk("b2b_acks", ack2, 3);
        chk("b2b_nlens", lens2.size(), 3);
        chk("b2b_ngaps", gaps2.size(), 2);
        while (lens2.size() > 0) chk("b2b_len", lens2.pop_front(), TL2);
        while (gaps2.size() > 0) chk("b2b_gap", gaps2.pop_front(), 1);

        // whole-run pin invariants
        chk("both_boards", xviol, 0);
        chk("sdi_while_high", sviol, 0);
        chk("ack_width", ack_long, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/afe_spi_sequencer.md
# afe_spi_sequencer

Serialises attenuator/configuration words to the two RF front-end (AFE) boards over the per-board SPI lines (AFE_SPI_CLK/SDI/LE[1:0]). A single shared shift engine is arbitrated between a software CSR requester and an automatic requester (e.g. attenuation tracking logic). The block sits in the system-clock domain of common_dsbpm_top, between the register bank and the AFE output pins.

## Interface
- WORD_WIDTH, 16: bits shifted per transaction, MSB first.
- CLK_DIV, 4: sysClk cycles per SPI half-period; legal range 2..255.

- sysClk  in  1  system clock; all logic on rising edge.
- sysReset_n  in  1  reset, asynchronous assert, active-low.
- csrStrobe  in  1  one-cycle write request from the register bank.
- csrData  in  32  [31] target board, [WORD_WIDTH-1:0] word, other bits ignored.
- csrOverrunClear  in  1  clears csrOverrun.
- csrStatus  out  32  [31] busy, [30] csrPending, [29] csrOverrun, [28] lastTarget, [WORD_WIDTH-1:0] last word sent.
- autoReq  in  1  level request; held until autoAck.
- autoTarget  in  1  target board for auto request.
- autoData  in  WORD_WIDTH  word for auto request.
- autoAck  out  1  one-cycle pulse when the auto request is granted and captured.
- spiClk  out  2  AFE_SPI_CLK per board.
- spiSdi  out  2  AFE_SPI_SDI per board.
- spiLe  out  2  AFE_SPI_LE per board.

## Operation
- csrStrobe captures target/word into a pending slot (csrPending=1). Strobe while pending: request dropped, csrOverrun set (sticky until csrOverrunClear; clear and set in same cycle -> set wins).
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP.
- IDLE: if csrPending or autoReq, grant. Both present: round-robin; priority goes to the requester not granted last; after reset CSR has priority. On grant load shift register and target, clear csrPending (CSR grant) or pulse autoAck (auto grant), go SHIFT_LO.
- SHIFT_LO: spiClk[t]=0, spiSdi[t]=current bit; after CLK_DIV cycles -> SHIFT_HI.
- SHIFT_HI: spiClk[t]=1, SDI stable; after CLK_DIV cycles shift left; if bits remain -> SHIFT_LO else -> LATCH.
- LATCH: spiClk[t]=0, spiLe[t]=1, SDI=0 for CLK_DIV cycles -> GAP.
- GAP: all lines low for CLK_DIV cycles; update lastTarget/last word; -> IDLE.
- Non-targeted board: spiClk/spiSdi/spiLe held 0 throughout.
- Counters: half-period counter 8 bits, bit counter ceil(log2(WORD_WIDTH+1)) bits; no arithmetic wrap permitted beyond terminal counts.
- A CSR strobe arriving during an active transaction is accepted into the pending slot (not an overrun unless pending already full).

## Timing
- Reset: state IDLE; spiClk, spiSdi, spiLe, autoAck = 0; csrPending, csrOverrun, lastTarget, last word = 0; round-robin pointer = CSR-first.
- All outputs registered; no combinational path from inputs to SPI pins.
- Request seen at edge N -> state SHIFT_LO, busy=1, MSB on SDI after edge N+1; autoAck high for the cycle following edge N+1.
- Transaction length (busy high): exactly (2*WORD_WIDTH+2)*CLK_DIV cycles; defaults -> 136 cycles. Next grant at earliest one cycle after return to IDLE.
- SDI changes only while spiClk low; AFE samples on rising spiClk; each bit held 2*CLK_DIV cycles.
- spiLe high exactly CLK_DIV cycles, only after all WORD_WIDTH rising edges.
- Reset mid-transaction: lines go low asynchronously; LE never asserts, so no partial word is latched.

## Test plan
- CSR write csrData=0x8000_A5C3, defaults -> board 1 only toggles: 16 rising edges, SDI sequence 1010010111000011, LE high 4 cycles, busy 136 cycles, board 0 lines stay 0, status[15:0]=0xA5C3, [28]=1.
- csrStrobe and autoReq (target 0, 0x1234) in same cycle after reset -> CSR word first, then auto word; autoAck single pulse at second grant; third simultaneous pair -> auto served first.
- Two csrStrobes during a transaction -> first pending, second sets csrOverrun; csrOverrunClear -> 0; pending word sent after current one.
- sysReset_n low at bit 8 of a transfer -> all spi lines 0 within same cycle, no LE pulse, status reads 0 after release.
- autoReq held continuously with CLK_DIV=2 -> back-to-back transfers each 68 cycles busy with one IDLE cycle between, autoAck once per transfer.
